// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit and its requesters.
//   FUNCT3_*      : multiply op encodings (mul, mulh, mulhsu, mulhu)
//   mul_owner_t   : which requester owns the multiplier stage
//   legal_funct3  : folds the undefined 1xx encodings onto mulhu
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    typedef enum logic {
        OWN_MDU = 1'b0,
        OWN_AUX = 1'b1
    } mul_owner_t;

    // The multiplier only understands 000-011; anything with bit 2 set is
    // quietly executed as an unsigned high multiply.
    function automatic logic [2:0] legal_funct3(input logic [2:0] f);
        return f[2] ? FUNCT3_MULHU : f;
    endfunction

endpackage

// File: rtl/mul_arb_if.sv
// -----------------------------------------------------------------------------
// mul_arb_if
// Bundle of everything between the two multiply requesters, the shared
// multiplier datapath and mul_arb.
//   Req*      : per-port request channel (valid/ready, operands, op, tag)
//   FlushReq  : per-port kill of in-flight op and current request
//   Mul*      : operands/op/control to the multiplier, product back
//   Rsp*      : per-port result valid/ready, shared data and tag
// Modports: slave = the arbiter, master = requesters + datapath side.
// -----------------------------------------------------------------------------
interface mul_arb_if #(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) ();

    logic [1:0]                 ReqValid;
    logic [1:0]                 ReqReady;
    logic [1:0][XLEN-1:0]       ReqSrcA;
    logic [1:0][XLEN-1:0]       ReqSrcB;
    logic [1:0][2:0]            ReqFunct3;
    logic [1:0][TAGW-1:0]       ReqTag;
    logic [1:0]                 FlushReq;

    logic [XLEN-1:0]            MulSrcA;
    logic [XLEN-1:0]            MulSrcB;
    logic [2:0]                 MulFunct3;
    logic                       MulStall;
    logic                       MulFlush;
    logic [2*XLEN-1:0]          MulProd;

    logic [1:0]                 RspValid;
    logic [1:0]                 RspReady;
    logic [XLEN-1:0]            RspData;
    logic [TAGW-1:0]            RspTag;

    modport slave (
        input  ReqValid, ReqSrcA, ReqSrcB, ReqFunct3, ReqTag, FlushReq,
        input  MulProd, RspReady,
        output ReqReady, MulSrcA, MulSrcB, MulFunct3, MulStall, MulFlush,
        output RspValid, RspData, RspTag
    );

    modport master (
        output ReqValid, ReqSrcA, ReqSrcB, ReqFunct3, ReqTag, FlushReq,
        output MulProd, RspReady,
        input  ReqReady, MulSrcA, MulSrcB, MulFunct3, MulStall, MulFlush,
        input  RspValid, RspData, RspTag
    );

endinterface

// File: rtl/mul_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. On a conflict the port that did not win last
// time is granted; a lone requester is always granted. Grants only appear
// while en_i is high, and the history bit only moves on an actual grant.
//   clk, reset : clock, asynchronous active-low reset
//   req_i      : per-port request
//   en_i       : grant enable
//   gnt_o      : one-hot grant (or zero)
//   last_o     : port granted most recently (resets to 1 so port 0 wins first)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            if (&req_i) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
        if (|gnt_o) begin
            last_d = gnt_o[1];
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/mul_arb.sv
// -----------------------------------------------------------------------------
// mul_arb
// Arbiter and sequencer in front of the shared one-register-stage multiplier.
// Grants one of two requesters per cycle (round-robin), steers its operands
// into the multiplier, and shadows the multiplier stage with a metadata
// register (valid, owner, op, tag) that advances under the same enable.
// The product half selected by the op is returned to the owner with
// valid/ready backpressure; a stalled result blocks new grants.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : mul_arb_if slave modport (requests, multiplier, responses)
// -----------------------------------------------------------------------------
module mul_arb
    import mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic     clk,
    input  logic     reset,
    mul_arb_if.slave bus
);

    // Metadata register shadowing the multiplier stage.
    logic            m_valid_q,  m_valid_d;
    mul_owner_t      m_owner_q,  m_owner_d;
    logic [2:0]      m_funct3_q, m_funct3_d;
    logic [TAGW-1:0] m_tag_q,    m_tag_d;

    logic       owner_idx;
    logic       owner_flush;
    logic       owner_ready;
    logic       drain;
    logic       stall;
    logic       slot_free;
    logic [1:0] eligible;
    logic [1:0] gnt;
    logic       grant_any;
    logic       gnt_port;
    logic       last;
    logic       sel;

    assign owner_idx   = m_owner_q;
    assign owner_flush = bus.FlushReq[owner_idx];
    assign owner_ready = bus.RspReady[owner_idx];

    assign drain     = m_valid_q & owner_ready & ~owner_flush;
    assign stall     = m_valid_q & ~owner_ready & ~owner_flush;
    // A flush by the owner frees the slot even without the result leaving.
    assign slot_free = ~m_valid_q | drain | owner_flush;

    // A port flushing this cycle withdraws its own request.
    assign eligible = bus.ReqValid & ~bus.FlushReq;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req_i  (eligible),
        .en_i   (slot_free),
        .gnt_o  (gnt),
        .last_o (last)
    );

    assign grant_any = |gnt;
    assign gnt_port  = gnt[1];
    // Without a grant the mux still points at a real port so the idle
    // operands are whatever that requester drives, never X.
    assign sel       = grant_any ? gnt_port : ~last;

    assign bus.ReqReady  = gnt;
    assign bus.MulSrcA   = bus.ReqSrcA[sel];
    assign bus.MulSrcB   = bus.ReqSrcB[sel];
    assign bus.MulFunct3 = legal_funct3(bus.ReqFunct3[sel]);
    assign bus.MulStall  = stall;
    // Scrub the datapath register when the owner kills its op and nothing
    // new is loaded behind it.
    assign bus.MulFlush  = owner_flush & m_valid_q & ~grant_any;

    always_comb begin
        m_valid_d  = m_valid_q;
        m_owner_d  = m_owner_q;
        m_funct3_d = m_funct3_q;
        m_tag_d    = m_tag_q;
        if (!stall) begin
            if (grant_any) begin
                m_valid_d  = 1'b1;
                m_owner_d  = gnt_port ? OWN_AUX : OWN_MDU;
                m_funct3_d = legal_funct3(bus.ReqFunct3[gnt_port]);
                m_tag_d    = bus.ReqTag[gnt_port];
            end else begin
                m_valid_d  = 1'b0;
            end
        end
    end

    // NOTE: the payload fields are reset along with the valid bit; they are
    // only a few flops and it keeps RspTag defined straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q  <= 1'b0;
            m_owner_q  <= OWN_MDU;
            m_funct3_q <= FUNCT3_MUL;
            m_tag_q    <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_owner_q  <= m_owner_d;
            m_funct3_q <= m_funct3_d;
            m_tag_q    <= m_tag_d;
        end
    end

    assign bus.RspValid[0] = m_valid_q & ~owner_idx & ~bus.FlushReq[0];
    assign bus.RspValid[1] = m_valid_q &  owner_idx & ~bus.FlushReq[1];
    assign bus.RspData     = (m_funct3_q == FUNCT3_MUL) ? bus.MulProd[XLEN-1:0]
                                                        : bus.MulProd[2*XLEN-1:XLEN];
    assign bus.RspTag      = m_tag_q;

endmodule

// File: tb/tb_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_mul_arb
// Bench for mul_arb: models the one-stage multiplier datapath, drives a table
// of single requests back to back, then hand-written sequences for
// round-robin, backpressure, flush and reset mid-operation. A monitor keeps a
// scoreboard of granted requests and checks each response against it.
// -----------------------------------------------------------------------------
module tb_mul_arb;
    import mdu_pkg::*;

    localparam int XLEN = 64;
    localparam int TAGW = 5;
    localparam logic [XLEN-1:0] ONES = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_arb_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    mul_arb #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- multiplier datapath model ----------------
    logic [2*XLEN-1:0] prod_q;

    function automatic logic [2*XLEN-1:0] ref_mul(input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b,
                                                  input logic [2:0] f);
        logic [2*XLEN-1:0] ea;
        logic [2*XLEN-1:0] eb;
        ea = {{XLEN{1'b0}}, a};
        eb = {{XLEN{1'b0}}, b};
        if (f == FUNCT3_MUL || f == FUNCT3_MULH) begin
            ea = {{XLEN{a[XLEN-1]}}, a};
            eb = {{XLEN{b[XLEN-1]}}, b};
        end else if (f == FUNCT3_MULHSU) begin
            ea = {{XLEN{a[XLEN-1]}}, a};
        end else if (f != FUNCT3_MULHU) begin
            return '0;  // undefined encodings never produce a useful value
        end
        return ea * eb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              prod_q <= '0;
        else if (bus.MulFlush)   prod_q <= '0;
        else if (!bus.MulStall)  prod_q <= ref_mul(bus.MulSrcA, bus.MulSrcB, bus.MulFunct3);
    end
    assign bus.MulProd = prod_q;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [2*XLEN-1:0] act,
                         input logic [2*XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            port;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    logic [XLEN-1:0] exp_data [2];

    // Monitor: runs 2 time units after each falling edge, after the driver.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            sb.delete();
            check("rsp_valid_in_reset", bus.RspValid, 2'b00);
        end else begin
            if (sb.size() > 0) begin
                mon_e = sb[0];
                if (bus.FlushReq[mon_e.port]) begin
                    check("flushed_no_rsp", bus.RspValid[mon_e.port], 1'b0);
                    void'(sb.pop_front());
                end else begin
                    check("rsp_valid", bus.RspValid, 2'b01 << mon_e.port);
                    if (bus.RspReady[mon_e.port]) begin
                        check($sformatf("rsp_data_tag%0d", mon_e.tag), bus.RspData, mon_e.data);
                        check($sformatf("rsp_tag_tag%0d", mon_e.tag), bus.RspTag, mon_e.tag);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check("no_spurious_rsp", bus.RspValid, 2'b00);
            end
            if (bus.ReqReady[0]) sb.push_back('{1'b0, bus.ReqTag[0], exp_data[0]});
            if (bus.ReqReady[1]) sb.push_back('{1'b1, bus.ReqTag[1], exp_data[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.ReqValid  = 2'b00;
        bus.FlushReq  = 2'b00;
        bus.RspReady  = 2'b11;
        bus.ReqSrcA   = '0;
        bus.ReqSrcB   = '0;
        bus.ReqFunct3 = '0;
        bus.ReqTag    = '0;
    endtask

    task automatic set_req(input int p, input logic [2:0] f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                           input logic [XLEN-1:0] exp);
        bus.ReqValid[p]  = 1'b1;
        bus.ReqFunct3[p] = f;
        bus.ReqSrcA[p]   = a;
        bus.ReqSrcB[p]   = b;
        bus.ReqTag[p]    = tag;
        exp_data[p]      = exp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", bus.ReqReady, 2'b00);
        check("rst_rsp_valid", bus.RspValid, 2'b00);
        check("rst_mul_stall", bus.MulStall, 1'b0);
        check("rst_mul_flush", bus.MulFlush, 1'b0);
        check("rst_outputs_known",
              {$isunknown(bus.RspData), $isunknown(bus.RspTag), $isunknown(bus.MulSrcA)}, 3'b000);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            port;
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vec [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b0, FUNCT3_MUL,    64'd3, 64'd5, 5'd7, 64'd15};
        vec[1] = '{1'b1, FUNCT3_MUL,    ONES,  64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE};
        vec[2] = '{1'b0, FUNCT3_MULH,   ONES,  ONES,  5'd1, 64'd0};
        vec[3] = '{1'b1, FUNCT3_MULHSU, ONES,  64'd2, 5'd2, ONES};
        vec[4] = '{1'b0, FUNCT3_MULHU,  ONES,  ONES,  5'd4, 64'hFFFF_FFFF_FFFF_FFFE};
        vec[5] = '{1'b1, FUNCT3_MULH,   64'h4000_0000_0000_0000, 64'd4, 5'd5, 64'd1};
        vec[6] = '{1'b0, FUNCT3_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                   5'd6, 64'h4000_0000_0000_0000};
        vec[7] = '{1'b1, 3'b100,        ONES,  ONES,  5'd8, 64'hFFFF_FFFF_FFFF_FFFE};
        vec[8] = '{1'b0, FUNCT3_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd9, ONES};
        vec[9] = '{1'b1, FUNCT3_MUL,    64'h1_0000_0001, 64'h1_0000_0001, 5'd10,
                   64'h2_0000_0001};

        idle_inputs();
        exp_data[0] = '0;
        exp_data[1] = '0;
        do_reset();

        // Table: one request per cycle, back to back, responses drained.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.ReqValid = 2'b00;
            set_req(int'(vec[i].port), vec[i].f, vec[i].a, vec[i].b, vec[i].tag, vec[i].exp);
            #1;
            check($sformatf("vec%0d_req_ready", i), bus.ReqReady, 2'b01 << vec[i].port);
        end
        @(negedge clk);
        bus.ReqValid = 2'b00;

        // Round-robin alternation from reset: grants 0,1,0,1.
        do_reset();
        @(negedge clk);
        set_req(0, FUNCT3_MUL, 64'd1, 64'd3, 5'd16, 64'd3);
        set_req(1, FUNCT3_MUL, 64'd2, 64'd3, 5'd17, 64'd6);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_grant%0d", k), bus.ReqReady, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            set_req(k % 2, FUNCT3_MUL, 64'(10 + k), 64'd3, 5'(18 + k), 64'(3 * (10 + k)));
        end
        bus.ReqValid = 2'b00;

        // Backpressure on port 1 for 3 cycles with port 0 waiting.
        @(negedge clk);
        bus.RspReady = 2'b01;
        set_req(1, FUNCT3_MULHU, ONES, ONES, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE);
        #1 check("bp_issue_ready", bus.ReqReady, 2'b10);
        @(negedge clk);
        bus.ReqValid = 2'b00;
        set_req(0, FUNCT3_MUL, 64'd6, 64'd7, 5'd12, 64'd42);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_stall%0d", k), bus.MulStall, 1'b1);
            check($sformatf("bp_ready%0d", k), bus.ReqReady, 2'b00);
            check($sformatf("bp_data%0d", k), bus.RspData, ONES - 1);
            @(negedge clk);
        end
        bus.RspReady = 2'b11;
        #1;
        check("bp_drain_grant", bus.ReqReady, 2'b01);
        check("bp_drain_stall", bus.MulStall, 1'b0);
        @(negedge clk);
        bus.ReqValid = 2'b00;

        // Flush of in-flight port 0 op while port 1 takes the slot.
        @(negedge clk);
        set_req(0, FUNCT3_MUL, 64'd9, 64'd9, 5'd13, 64'd81);
        #1 check("fl_issue_ready", bus.ReqReady, 2'b01);
        @(negedge clk);
        bus.ReqValid = 2'b00;
        bus.FlushReq = 2'b01;
        set_req(1, FUNCT3_MUL, 64'd4, 64'd4, 5'd14, 64'd16);
        #1;
        check("fl_other_grant", bus.ReqReady, 2'b10);
        check("fl_rsp_valid", bus.RspValid, 2'b00);
        check("fl_mulflush_with_grant", bus.MulFlush, 1'b0);
        @(negedge clk);
        bus.FlushReq = 2'b00;
        bus.ReqValid = 2'b00;

        // Flush with nothing behind it scrubs the datapath register.
        @(negedge clk);
        set_req(0, FUNCT3_MUL, 64'd5, 64'd5, 5'd15, 64'd25);
        #1 check("fl2_issue_ready", bus.ReqReady, 2'b01);
        @(negedge clk);
        bus.ReqValid = 2'b00;
        bus.FlushReq = 2'b01;
        #1;
        check("fl2_mulflush", bus.MulFlush, 1'b1);
        check("fl2_rsp_valid", bus.RspValid, 2'b00);
        @(negedge clk);
        bus.FlushReq = 2'b00;
        #1 check("fl2_after", bus.RspValid, 2'b00);

        // Flush and request on the same port: not granted.
        @(negedge clk);
        bus.FlushReq = 2'b01;
        set_req(0, FUNCT3_MUL, 64'd2, 64'd2, 5'd25, 64'd4);
        #1 check("fl_same_port_no_grant", bus.ReqReady, 2'b00);
        @(negedge clk);
        bus.FlushReq = 2'b00;
        bus.ReqValid = 2'b00;

        // Reset while an op is stalled in M.
        @(negedge clk);
        bus.RspReady = 2'b10;
        set_req(0, FUNCT3_MUL, 64'd7, 64'd7, 5'd22, 64'd49);
        #1 check("rm_issue_ready", bus.ReqReady, 2'b01);
        @(negedge clk);
        bus.ReqValid = 2'b00;
        #1;
        check("rm_stalled", bus.MulStall, 1'b1);
        check("rm_valid_before", bus.RspValid, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rm_in_reset_valid", bus.RspValid, 2'b00);
        check("rm_in_reset_stall", bus.MulStall, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        bus.RspReady = 2'b11;
        @(negedge clk);
        set_req(0, FUNCT3_MUL, 64'd2, 64'd2, 5'd23, 64'd4);
        set_req(1, FUNCT3_MUL, 64'd3, 64'd3, 5'd24, 64'd9);
        #1;
        check("rm_after_valid", bus.RspValid, 2'b00);
        check("rm_first_conflict", bus.ReqReady, 2'b01);
        @(negedge clk);
        bus.ReqValid = 2'b10;
        #1 check("rm_second_grant", bus.ReqReady, 2'b10);
        @(negedge clk);
        bus.ReqValid = 2'b00;

        repeat (3) @(negedge clk);
        #3;
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
